// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, credit-limited memory requests, response FIFO, redirect flush
// Optional FETCH_MISALIGN_CHECK_EN: a misaligned redirect raises fetch_misaligned and halts request issue.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic        fetch_misaligned
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] count;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   fifo_pc   [DEPTH];
    logic [31:0]   fifo_word [DEPTH];
    logic          halted;
    logic          req_fire;
    logic          push;
    logic          pop;

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted <= 1'b0;
        end else if (redirect_valid) begin
            halted <= |redirect_pc[1:0];
        end
    end
    assign fetch_misaligned = halted;
`else
    logic unused_low_pc;
    assign unused_low_pc    = ^redirect_pc[1:0];
    assign halted           = 1'b0;
    assign fetch_misaligned = 1'b0;
`endif

    // Credits cover both in-flight requests and buffered words, so a response always has a free slot.
    assign imem_req_valid = !rst && !redirect_valid && !halted &&
                            (({1'b0, outstanding} + {1'b0, count}) < DEPTH_W);
    assign imem_addr      = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign push           = imem_resp_valid && (discard == '0);
    assign inst_valid     = (count != '0);
    assign pop            = inst_valid && inst_ready;
    assign instruction    = fifo_word[rd_ptr];
    assign inst_pc        = fifo_pc[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc[i]   <= RESET_PC;
                fifo_word[i] <= '0;
            end
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);
            if (redirect_valid) begin
                // Every response still owed by memory belongs to the old stream and must be dropped.
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                resp_pc  <= {redirect_pc[31:2], 2'b00};
                discard  <= outstanding - CW'(imem_resp_valid);
                count    <= '0;
                wr_ptr   <= rd_ptr;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (imem_resp_valid && (discard != '0)) begin
                    discard <= discard - CW'(1);
                end
                if (push) begin
                    fifo_pc[wr_ptr]   <= resp_pc;
                    fifo_word[wr_ptr] <= imem_rdata;
                    wr_ptr            <= wr_ptr + AW'(1);
                    resp_pc           <= resp_pc + 32'd4;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit against an epoch-tagged memory/stream model
module tb_fetch_unit;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic        fetch_misaligned;

    fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_resp_valid(imem_resp_valid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instruction(instruction), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .fetch_misaligned(fetch_misaligned)
    );

    always #5 clk = ~clk;

    // Each accepted request is tagged with the stream epoch it belongs to; a redirect or reset starts a new epoch.
    typedef struct { logic [31:0] addr; int due; int ep; } req_t;
    req_t pend[$];
    int   epoch = 0, cyc = 0, model_fifo = 0, passed = 0, total = 0;
    int   ready_pct = 100, resp_pct = 100, lat_max = 0;
    bit   hold_resp = 0, halted_m = 0, last_wait = 0;
    logic [31:0] exp_fetch = RST_PC, exp_pc = RST_PC, last_addr = '0;

    bit          s_req, s_acc, s_pop, s_iv, s_mis, s_req_exp, s_hold_ok;
    logic [31:0] s_addr, s_pc, s_word, s_exp_pc, s_exp_fetch;
    int          s_credit;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5EED_C0DE;
    endfunction

    task automatic clear_model();
        pend.delete();
        epoch++;
        model_fifo = 0;
        exp_fetch  = RST_PC;
        exp_pc     = RST_PC;
        halted_m   = 0;
        last_wait  = 0;
        redirect_valid = 0; imem_req_ready = 0; imem_resp_valid = 0; inst_ready = 0;
    endtask

    task automatic reset_on();
        @(negedge clk);
        rst = 1'b1;
        clear_model();
    endtask

    task automatic reset_off();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic step(input bit redir, input logic [31:0] rpc, input bit irdy);
        req_t r;
        bit   resp;
        @(negedge clk);
        redirect_valid = redir;
        redirect_pc    = rpc;
        inst_ready     = irdy;
        imem_req_ready = ($urandom_range(99) < ready_pct);
        s_credit  = pend.size() + model_fifo;
        s_req_exp = !redir && (s_credit < DEPTH) && !halted_m;
        resp = 0;
        if (!hold_resp && pend.size() > 0 && pend[0].due <= cyc && $urandom_range(99) < resp_pct) begin
            resp = 1;
            r = pend.pop_front();
        end
        imem_resp_valid = resp;
        imem_rdata      = resp ? word_of(r.addr) : $urandom;
        #1;
        s_req = imem_req_valid; s_addr = imem_addr; s_iv = inst_valid;
        s_pc = inst_pc; s_word = instruction; s_mis = fetch_misaligned;
        s_acc = s_req && imem_req_ready;
        s_pop = s_iv && irdy && !redir;
        s_exp_pc = exp_pc; s_exp_fetch = exp_fetch;
        s_hold_ok = !(last_wait && !redir) || (s_req && s_addr == last_addr);
        last_wait = s_req && !imem_req_ready;
        last_addr = s_addr;
        if (redir) begin
            epoch++;
            exp_fetch  = {rpc[31:2], 2'b00};
            exp_pc     = exp_fetch;
            model_fifo = 0;
`ifdef FETCH_MISALIGN_CHECK_EN
            halted_m = (rpc[1:0] != 2'b00);
`endif
        end else begin
            if (s_pop) begin model_fifo--; exp_pc += 32'd4; end
            if (resp && r.ep == epoch) model_fifo++;
        end
        if (s_acc) begin
            pend.push_back('{addr: s_addr, due: cyc + 1 + int'($urandom_range(lat_max)), ep: epoch});
            exp_fetch += 32'd4;
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        ready_pct = 100; resp_pct = 100; lat_max = 0; hold_resp = 0;
        reset_on();
        #1;
        total++; if (imem_req_valid !== 1'b0) $display("FAIL reset_req_valid got %b want 0", imem_req_valid); else passed++;
        total++; if (imem_addr !== RST_PC) $display("FAIL reset_addr got %h want %h", imem_addr, RST_PC); else passed++;
        total++; if (inst_valid !== 1'b0) $display("FAIL reset_inst_valid got %b want 0", inst_valid); else passed++;
        total++; if (instruction !== 32'h0) $display("FAIL reset_instruction got %h want 0", instruction); else passed++;
        total++; if (inst_pc !== RST_PC) $display("FAIL reset_inst_pc got %h want %h", inst_pc, RST_PC); else passed++;
        total++; if (fetch_misaligned !== 1'b0) $display("FAIL reset_misaligned got %b want 0", fetch_misaligned); else passed++;
        reset_off();
        step(0, 0, 1);
        total++; if (s_req !== 1'b1 || s_addr !== RST_PC)
            $display("FAIL first_request got valid=%b addr=%h want 1 %h", s_req, s_addr, RST_PC); else passed++;
    endtask

    task automatic test_stream();
        logic [31:0] pcs [3];
        int          cys [3];
        int          n = 0;
        reset_on();
        reset_off();
        for (int i = 0; i < 30 && n < 3; i++) begin
            step(0, 0, 1);
            if (s_pop) begin
                pcs[n] = s_pc; cys[n] = cyc;
                total++; if (s_word !== word_of(s_pc)) $display("FAIL stream_word got %h want %h", s_word, word_of(s_pc)); else passed++;
                n++;
            end
        end
        total++; if (n != 3) $display("FAIL stream_count got %0d want 3", n); else passed++;
        if (n == 3) begin
            total++; if (pcs[0] !== 32'h100 || pcs[1] !== 32'h104 || pcs[2] !== 32'h108)
                $display("FAIL stream_pcs got %h %h %h want 100 104 108", pcs[0], pcs[1], pcs[2]); else passed++;
            total++; if (cys[1] != cys[0] + 1 || cys[2] != cys[1] + 1)
                $display("FAIL stream_consecutive got cycles %0d %0d %0d want consecutive", cys[0], cys[1], cys[2]); else passed++;
        end
    endtask

    task automatic test_backpressure();
        int pops = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0);
            total++; if (s_req !== s_req_exp)
                $display("FAIL stall_credit got req=%b want %b (outstanding+fifo=%0d)", s_req, s_req_exp, s_credit); else passed++;
        end
        total++; if (s_iv !== 1'b1 || s_req !== 1'b0)
            $display("FAIL stall_full got inst_valid=%b req=%b want 1 0", s_iv, s_req); else passed++;
        ready_pct = 0;
        for (int i = 0; i < 2 * DEPTH; i++) begin
            step(0, 0, 1);
            if (s_pop) begin
                pops++;
                total++; if (s_pc !== s_exp_pc) $display("FAIL release_pc got %h want %h", s_pc, s_exp_pc); else passed++;
            end
        end
        total++; if (pops != DEPTH) $display("FAIL release_count got %0d want %0d", pops, DEPTH); else passed++;
        ready_pct = 100;
    endtask

    task automatic test_redirect_flush();
        bit done = 0;
        reset_on();
        reset_off();
        hold_resp = 1;
        step(0, 0, 0);
        step(0, 0, 0);
        step(1, 32'h2000, 1);
        hold_resp = 0;
        step(0, 0, 1);
        total++; if (s_req !== 1'b1 || s_addr !== 32'h2000)
            $display("FAIL redirect_next_req got valid=%b addr=%h want 1 00002000", s_req, s_addr); else passed++;
        for (int k = 2; k < 30 && !done; k++) begin
            step(0, 0, 1);
            if (s_iv) begin
                done = 1;
                total++; if (s_pc !== 32'h2000) $display("FAIL flush_first_pc got %h want 00002000", s_pc); else passed++;
                total++; if (k < 3) $display("FAIL flush_latency got %0d cycles want >= 3", k); else passed++;
            end
        end
        total++; if (!done) $display("FAIL flush_timeout got no instruction want pc 00002000"); else passed++;
    endtask

    task automatic test_redirect_same_cycle();
        bit done = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 1);
            if (s_iv && pend.size() > 0) break;
        end
        step(1, 32'h4000, 1);
        step(0, 0, 1);
        total++; if (s_iv !== 1'b0) $display("FAIL same_cycle_flush got inst_valid=%b want 0", s_iv); else passed++;
        for (int i = 0; i < 30 && !done; i++) begin
            step(0, 0, 1);
            if (s_iv) begin
                done = 1;
                total++; if (s_pc !== 32'h4000) $display("FAIL same_cycle_pc got %h want 00004000", s_pc); else passed++;
            end
        end
        total++; if (!done) $display("FAIL same_cycle_timeout got no instruction want pc 00004000"); else passed++;
    endtask

    task automatic test_wrap();
        logic [31:0] pcs [3];
        int          n = 0;
        step(1, 32'hFFFF_FFF8, 1);
        for (int i = 0; i < 30 && n < 3; i++) begin
            step(0, 0, 1);
            if (s_pop) begin pcs[n] = s_pc; n++; end
        end
        total++; if (n != 3) $display("FAIL wrap_count got %0d want 3", n); else passed++;
        if (n == 3) begin
            total++; if (pcs[0] !== 32'hFFFF_FFF8 || pcs[1] !== 32'hFFFF_FFFC || pcs[2] !== 32'h0000_0000)
                $display("FAIL wrap_pcs got %h %h %h want fffffff8 fffffffc 00000000", pcs[0], pcs[1], pcs[2]); else passed++;
        end
    endtask

    task automatic test_misalign();
        bit          done = 0;
        logic [31:0] want;
        int          reqs = 0;
        step(1, 32'h1002, 1);
`ifdef FETCH_MISALIGN_CHECK_EN
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 1);
            if (s_req) reqs++;
        end
        total++; if (s_mis !== 1'b1) $display("FAIL misalign_flag got %b want 1", s_mis); else passed++;
        total++; if (reqs != 0) $display("FAIL misalign_halt got %0d requests want 0", reqs); else passed++;
        step(1, 32'h3000, 1);
        step(0, 0, 1);
        total++; if (s_mis !== 1'b0) $display("FAIL misalign_clear got %b want 0", s_mis); else passed++;
        want = 32'h3000;
`else
        step(0, 0, 1);
        total++; if (s_mis !== 1'b0) $display("FAIL misalign_tied got %b want 0", s_mis); else passed++;
        total++; if (s_req !== 1'b1 || s_addr !== 32'h1000)
            $display("FAIL misalign_addr got valid=%b addr=%h want 1 00001000", s_req, s_addr); else passed++;
        want = 32'h1000;
`endif
        for (int i = 0; i < 30 && !done; i++) begin
            step(0, 0, 1);
            if (s_iv) begin
                done = 1;
                total++; if (s_pc !== want) $display("FAIL misalign_resume_pc got %h want %h", s_pc, want); else passed++;
            end
        end
        total++; if (!done) $display("FAIL misalign_timeout got no instruction want pc %h", want); else passed++;
    endtask

    task automatic test_random();
        int          pops = 0;
        bit          redir;
        logic [31:0] rpc;
        reset_on();
        reset_off();
        ready_pct = 70; resp_pct = 70; lat_max = 3;
        for (int i = 0; i < 1500; i++) begin
            redir = ($urandom_range(99) < 3);
            rpc   = $urandom;
            if ($urandom_range(3) != 0) rpc[1:0] = 2'b00;
            if ($urandom_range(4) == 0) rpc = 32'hFFFF_FFF0;
            step(redir, rpc, $urandom_range(99) < 70);
            total++; if (s_req !== s_req_exp)
                $display("FAIL rand_req_valid cyc %0d got %b want %b", cyc, s_req, s_req_exp); else passed++;
            total++; if (!s_hold_ok) $display("FAIL rand_addr_hold cyc %0d got addr=%h valid=%b want %h held", cyc, s_addr, s_req, last_addr); else passed++;
            total++; if (s_mis !== halted_m && !redir) $display("FAIL rand_misaligned cyc %0d got %b want %b", cyc, s_mis, halted_m); else passed++;
            if (s_acc) begin
                total++; if (s_addr !== s_exp_fetch) $display("FAIL rand_addr cyc %0d got %h want %h", cyc, s_addr, s_exp_fetch); else passed++;
            end
            if (s_pop) begin
                pops++;
                total++; if (s_pc !== s_exp_pc || s_word !== word_of(s_exp_pc))
                    $display("FAIL rand_pop cyc %0d got pc=%h word=%h want %h %h", cyc, s_pc, s_word, s_exp_pc, word_of(s_exp_pc)); else passed++;
            end
        end
        total++; if (pops < 50) $display("FAIL rand_progress got %0d pops want >= 50", pops); else passed++;
    endtask

    task automatic test_reset_mid();
        ready_pct = 100; resp_pct = 100; lat_max = 0;
        step(1, 32'h0000_8000, 1);
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0);
            if (s_iv) break;
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0)
            $display("FAIL midreset_valids got req=%b inst=%b want 0 0", imem_req_valid, inst_valid); else passed++;
        total++; if (imem_addr !== RST_PC || inst_pc !== RST_PC || instruction !== 32'h0)
            $display("FAIL midreset_values got addr=%h pc=%h instr=%h want %h %h 0", imem_addr, inst_pc, instruction, RST_PC, RST_PC); else passed++;
        clear_model();
        reset_off();
        step(0, 0, 1);
        total++; if (s_req !== 1'b1 || s_addr !== RST_PC)
            $display("FAIL midreset_restart got valid=%b addr=%h want 1 %h", s_req, s_addr, RST_PC); else passed++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_flush();
        test_redirect_same_cycle();
        test_wrap();
        test_misalign();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
